bt_bin2tern_seq: RTL
====================

# bt_bin2tern_seq

Iterative signed-binary to balanced-ternary converter producing one trit per cycle. It sits at the binary/ternary boundary in front of the ternary datapath. It converts two's-complement operands (immediates, host/debug writes, memory-mapped values) into the packed 2-bit-per-trit form consumed by the 8-trit ALU and register file. Both sides use valid/ready handshakes, latency is fixed, and an overflow indication is produced when the value exceeds the trit range.

## Interface
Parameters:
- `WIDTH`, default 8: number of output trits.
- `BIN_W`, default 16: width of the signed binary input.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_data`, input, `BIN_W`: signed two's-complement value to convert.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept an input. Equal to `(state == IDLE)`.
- `out_trits`, output, `2*WIDTH`: packed balanced-ternary result. Trit k occupies bits `[2k+1:2k]`.
- `out_overflow`, output, 1: value outside ±(3^WIDTH−1)/2. Meaningful only while `out_valid` is high.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer accepts the result.

## Operation
- Trit encoding comes from the shared defines: −1 = 2'b00, 0 = 2'b01, +1 = 2'b10, invalid = 2'b11. The block never emits the invalid code.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - On `in_valid && in_ready`: load working register `x` with `in_data` sign-extended to `BIN_W+1` bits.
  - Load `out_trits` with all-zero trits.
  - Clear trit counter `cnt`, clear `out_overflow`, go to CONV.
- CONV, each cycle:
  - r = x mod 3 (mathematical, in {0,1,2}).
  - r=0: trit 0, x ← x/3.
  - r=1: trit +1, x ← (x−1)/3.
  - r=2: trit −1, x ← (x+1)/3. Division is exact.
  - Shift the trit in at the MSB end: `out_trits ← {trit, out_trits[2*WIDTH-1:2]}`. After WIDTH shifts, trit 0 sits at bits [1:0].
  - `cnt` increments. When `cnt == WIDTH−1`, go to DONE.
  - On the last step, `out_overflow ← (next x != 0)`.
- DONE:
  - `out_valid = 1`. `out_trits` and `out_overflow` are held stable.
  - On `out_ready`, go to IDLE.
- Overflow result: `out_trits` holds the low WIDTH trits of the infinite balanced expansion, i.e. `in_data` wrapped modulo 3^WIDTH into the balanced range.
- `BIN_W+1` bit working width makes `(x+1)` safe at `x = 2^(BIN_W−1)−1`.
- `in_data` is sampled only on the accept edge. Changes at any other time are ignored.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_trits` = all-zero trits (16'h5555 at WIDTH=8), `out_overflow` 0, `cnt` 0.
- Latency: input accepted at edge E0 gives `out_valid` high after edge E_WIDTH, i.e. WIDTH cycles. The latency is fixed and there is no early termination for small values.
- Throughput: at most one conversion per WIDTH+2 cycles. No input is accepted in the cycle the output handshake completes; `in_ready` rises the cycle after.
- `in_ready` is low throughout CONV and DONE.
- `out_valid` may remain high indefinitely. Backpressure has no side effects.
- `rst` asserted in any state, including mid-CONV or DONE with `out_valid` high, returns all outputs to reset values at the next edge. The partial result is discarded.
- `out_trits` is visible during CONV as a shifting value, but consumers and the bench sample it only while `out_valid` is high.

## Structure
- Shared ternary package/defines:
  - Trit codes `T_NEG_ONE`, `T_ZERO`, `T_POS_ONE`, `T_INVALID`.
  - The all-zero word constant.
  - The FSM state typedef, reused by later ternary-side sequential blocks.
- Sub-module `bt_div3_step`: combinational, width `BIN_W+1`. Input `x`; outputs `trit[1:0]` and quotient `q`. It contains all mod-3/div-3 logic so the FSM module holds only the handshake, counter and registers.

## Test plan
- Reset, then `in_data` = 5 → after 8 cycles `out_valid`=1, `out_trits` = 16'h5560, `out_overflow` = 0.
- `in_data` = −5 → 16'h554A.
- `in_data` = 0 → 16'h5555.
- `in_data` = 3280 → 16'hAAAA.
- `in_data` = −3280 → 16'h0000.
- All four of the previous values give `out_overflow` = 0.
- `in_data` = 3281 → `out_trits` = 16'h0000, `out_overflow` = 1.
- `in_data` = −32768 and 32767 → `out_overflow` = 1, and the result matches a reference model mod 3^8.
- Hold `out_ready` = 0 for 20 cycles in DONE → `out_trits` stable, `in_ready` = 0, new `in_valid` ignored. Release → `in_ready` = 1 one cycle later.
- Assert `rst` at CONV cycle 3 → next edge: `out_valid` 0, `in_ready` 1, `out_trits` 16'h5555. Then a new conversion of 5 completes correctly.
- Randomized back-to-back conversions with random `out_ready` stalls → every result matches the model, and no code 2'b11 ever appears.

Source files
------------

// File: rtl/bt_bin2tern_seq_pkg.sv
// Shared ternary definitions: trit codes, the all-zero word and the common FSM state type.
package bt_bin2tern_seq_pkg;

    localparam logic [1:0] T_NEG_ONE = 2'b00;
    localparam logic [1:0] T_ZERO    = 2'b01;
    localparam logic [1:0] T_POS_ONE = 2'b10;
    localparam logic [1:0] T_INVALID = 2'b11;

    // Wide enough for any practical word; blocks slice the low 2*WIDTH bits.
    localparam int         MAX_TRITS   = 32;
    localparam logic [2*MAX_TRITS-1:0] T_ZERO_WORD = {MAX_TRITS{T_ZERO}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } bt_state_e;

endpackage

// File: rtl/bt_div3_step.sv
// One balanced-ternary digit step: emits the low trit of x and the exact quotient (x - trit) / 3.
module bt_div3_step
    import bt_bin2tern_seq_pkg::*;
#(
    parameter int W = 17
) (
    input  logic signed [W-1:0] x,
    output logic        [1:0]   trit,
    output logic signed [W-1:0] q
);

    localparam logic signed [W-1:0] THREE = W'(3);

    logic signed [W-1:0] w_m;
    logic signed [W-1:0] w_r;
    logic signed [W-1:0] w_adj;

    // Truncating % follows the dividend sign; fold into {0,1,2}.
    assign w_m = x % THREE;
    assign w_r = w_m[W-1] ? (w_m + THREE) : w_m;

    always_comb begin
        trit  = T_ZERO;
        w_adj = x;
        if (w_r == W'(1)) begin
            trit  = T_POS_ONE;
            w_adj = x - W'(1);
        end else if (w_r == W'(2)) begin
            trit  = T_NEG_ONE;
            w_adj = x + W'(1);
        end
    end

    assign q = w_adj / THREE;

endmodule

// File: rtl/bt_bin2tern_seq.sv
// Iterative two's-complement to balanced-ternary converter, one trit per cycle, valid/ready on both sides.
module bt_bin2tern_seq
    import bt_bin2tern_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BIN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIN_W-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   out_trits,
    output logic                 out_overflow,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int XW    = BIN_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [2*WIDTH-1:0] ZWORD = T_ZERO_WORD[2*WIDTH-1:0];

    bt_state_e                r_state;
    bt_state_e                w_state_nxt;
    logic signed [XW-1:0]     r_x;
    logic [2*WIDTH-1:0]       r_trits;
    logic                     r_ovf;
    logic [CNT_W-1:0]         r_cnt;

    logic [1:0]               w_trit;
    logic signed [XW-1:0]     w_q;
    logic                     w_accept;
    logic                     w_last;

    bt_div3_step #(.W(XW)) u_step (
        .x    (r_x),
        .trit (w_trit),
        .q    (w_q)
    );

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_CONV;
            ST_CONV: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_trits <= ZWORD;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_x     <= {in_data[BIN_W-1], in_data};
                    r_trits <= ZWORD;
                    r_ovf   <= 1'b0;
                    r_cnt   <= '0;
                end
                ST_CONV: begin
                    // Trits enter at the MSB end so trit 0 lands at [1:0] after WIDTH shifts.
                    r_x     <= w_q;
                    r_trits <= {w_trit, r_trits[2*WIDTH-1:2]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) r_ovf <= (w_q != '0);
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_trits    = r_trits;
    assign out_overflow = r_ovf;

endmodule
